// File: rtl/filter_out_buffer.sv
// Output stage of the adaptive filter: drops transient samples after a mode change,
// rounds/saturates Q8.6 to Q8.4, buffers into a FWFT FIFO. Macro: FILTER_OUT_BUF_DROP_CNT_EN.
module filter_out_buffer #(
  parameter int IN_WL         = 14,
  parameter int IN_FL         = 6,
  parameter int OUT_WL        = 12,
  parameter int OUT_FL        = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int BLANK_SAMPLES = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl,
  input  logic [IN_WL-1:0]              s_tdata,
  input  logic                          s_tvalid,
  output logic [OUT_WL-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic                          clr_ovf,
  output logic                          overflow,
  output logic                          blanking,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [15:0]                   drop_cnt
);

  localparam int SH = IN_FL - OUT_FL;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BLANK_SAMPLES + 1);
  localparam logic [IN_WL:0] HALF    = (IN_WL+1)'(2 ** (SH - 1));
  localparam logic [IN_WL:0] HALF_M1 = (IN_WL+1)'(2 ** (SH - 1) - 1);

  logic          ctrl_q;
  logic          ctrl_vld;
  logic          ctrl_chg;
  logic [BW-1:0] blank_cnt;
  logic          take;

  // ctrl_vld suppresses a false mode change on the first edge after reset
  assign ctrl_chg = ctrl_vld && (ctrl != ctrl_q);
  assign take     = s_tvalid && !ctrl_chg && (blank_cnt == '0);
  assign blanking = (blank_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= 1'b0;
      ctrl_vld  <= 1'b0;
      blank_cnt <= '0;
    end else begin
      ctrl_q   <= ctrl;
      ctrl_vld <= 1'b1;
      if (ctrl_chg)
        blank_cnt <= BW'(BLANK_SAMPLES);
      else if (s_tvalid && (blank_cnt != '0))
        blank_cnt <= blank_cnt - BW'(1);
    end
  end

  logic [IN_WL:0]    x_ext;
  logic [IN_WL:0]    x_bias;
  logic [OUT_WL:0]   rnd;
  logic [OUT_WL-1:0] sat;

  // Negative values get half-minus-one so the arithmetic shift rounds away from zero
  always_comb begin
    x_ext  = {s_tdata[IN_WL-1], s_tdata};
    x_bias = x_ext + (s_tdata[IN_WL-1] ? HALF_M1 : HALF);
    rnd    = (OUT_WL+1)'($signed(x_bias) >>> SH);
    sat    = rnd[OUT_WL-1:0];
    if (rnd[OUT_WL] != rnd[OUT_WL-1])
      sat = rnd[OUT_WL] ? {1'b1, {(OUT_WL-1){1'b0}}} : {1'b0, {(OUT_WL-1){1'b1}}};
  end

  logic              s1_valid;
  logic [OUT_WL-1:0] s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= take;
      if (take)
        s1_data <= sat;
    end
  end

  logic [OUT_WL-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              rd_en;
  logic              wr_en;
  logic              drop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign rd_en    = !empty && m_tready;
  assign wr_en    = s1_valid && (!full || rd_en);
  assign drop     = s1_valid && full && !rd_en;
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= s1_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + (AW+1)'(1);
        2'b01:   fill_level <= fill_level - (AW+1)'(1);
        default: fill_level <= fill_level;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

`ifdef FILTER_OUT_BUF_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (clr_ovf)
      drop_cnt <= {15'd0, drop};
    else if (drop && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_filter_out_buffer.sv
// Scoreboard bench for filter_out_buffer: a queue-based reference model predicts FIFO
// contents, occupancy, blanking and overflow; every output is compared on the falling edge.
module tb_filter_out_buffer;

  localparam int IN_WL  = 14;
  localparam int IN_FL  = 6;
  localparam int OUT_WL = 12;
  localparam int OUT_FL = 4;
  localparam int DEPTH  = 16;
  localparam int BLANK  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              ctrl;
  logic [IN_WL-1:0]  s_tdata;
  logic              s_tvalid;
  logic [OUT_WL-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              clr_ovf;
  logic              overflow;
  logic              blanking;
  logic [4:0]        fill_level;
  logic [15:0]       drop_cnt;

  filter_out_buffer #(
    .IN_WL(IN_WL), .IN_FL(IN_FL), .OUT_WL(OUT_WL), .OUT_FL(OUT_FL),
    .FIFO_DEPTH(DEPTH), .BLANK_SAMPLES(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .clr_ovf(clr_ovf),
    .overflow(overflow), .blanking(blanking), .fill_level(fill_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [OUT_WL-1:0] exp_q[$];
  int                lvl;
  int                blank;
  int                drops;
  bit                ovf;
  bit                pend_v;
  logic [OUT_WL-1:0] pend_d;
  bit                ctrl_known;
  logic              ctrl_prev;

  // sign(x) * floor(|x| * 2^OUT_FL / 2^IN_FL + 1/2), clamped to the output range
  function automatic logic [OUT_WL-1:0] ref_round(input logic [IN_WL-1:0] d);
    int x, ax, r;
    x  = int'($signed(d));
    ax = (x < 0) ? -x : x;
    r  = (ax * (2 ** (OUT_FL + 1)) + 2 ** IN_FL) / (2 ** (IN_FL + 1));
    if (x < 0) r = -r;
    if (r > 2 ** (OUT_WL - 1) - 1) r = 2 ** (OUT_WL - 1) - 1;
    if (r < -(2 ** (OUT_WL - 1))) r = -(2 ** (OUT_WL - 1));
    return r[OUT_WL-1:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge, so at the falling edge they are exactly what
  // the next rising edge samples: compare state, then advance the model by one edge.
  always @(negedge clk) begin
    bit rd, drop, chg;
    int exp_dc;
    if (rst) begin
      chk("rst_m_tvalid",   int'(m_tvalid),   0);
      chk("rst_fill_level", int'(fill_level), 0);
      chk("rst_overflow",   int'(overflow),   0);
      chk("rst_blanking",   int'(blanking),   0);
      chk("rst_drop_cnt",   int'(drop_cnt),   0);
      chk("rst_m_tdata",    int'(m_tdata),    0);
      exp_q.delete();
      lvl = 0; blank = 0; drops = 0; ovf = 0; pend_v = 0; ctrl_known = 0;
    end else begin
`ifdef FILTER_OUT_BUF_DROP_CNT_EN
      exp_dc = drops;
`else
      exp_dc = 0;
`endif
      chk("m_tvalid",   int'(m_tvalid),   (lvl > 0) ? 1 : 0);
      chk("fill_level", int'(fill_level), lvl);
      chk("overflow",   int'(overflow),   int'(ovf));
      chk("blanking",   int'(blanking),   (blank != 0) ? 1 : 0);
      chk("drop_cnt",   int'(drop_cnt),   exp_dc);
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_tdata actual=%0h expected=none (queue empty) at %0t", m_tdata, $time);
        end else begin
          chk("m_tdata", int'(m_tdata), int'(exp_q[0]));
        end
      end

      rd = (lvl > 0) && m_tready;
      if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
      drop = 0;
      if (pend_v) begin
        if (lvl < DEPTH || rd) begin
          exp_q.push_back(pend_d);
          lvl++;
        end else begin
          drop = 1;
        end
      end
      if (rd) lvl--;
      if (drop) ovf = 1;
      else if (clr_ovf) ovf = 0;
      if (clr_ovf) drops = drop ? 1 : 0;
      else if (drop && drops < 65535) drops++;

      chg        = ctrl_known && (ctrl != ctrl_prev);
      ctrl_prev  = ctrl;
      ctrl_known = 1;
      pend_v     = 0;
      if (chg) begin
        blank = BLANK;
      end else if (s_tvalid) begin
        if (blank > 0) blank--;
        else begin
          pend_v = 1;
          pend_d = ref_round(s_tdata);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [IN_WL-1:0] d);
    s_tvalid = v;
    s_tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  logic [IN_WL-1:0] rvec [6];
  logic [IN_WL-1:0] dv;

  initial begin
    rst = 1'b1; ctrl = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; clr_ovf = 1'b0;
    rvec[0] = 14'h0006; rvec[1] = 14'h3FFA; rvec[2] = 14'h0005;
    rvec[3] = 14'h3FFB; rvec[4] = 14'h1FFF; rvec[5] = 14'h2000;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // rounding and saturation corners
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, rvec[i]);
    idle(4);

    // back-to-back stream
    for (int k = 1; k <= 20; k++) step(1'b1, 14'(k * 64));
    idle(4);

    // blanking after a toggle, then a re-toggle mid-blanking, then a toggle with a sample
    ctrl = 1'b1; step(1'b0, '0);
    for (int k = 1; k <= 10; k++) step(1'b1, 14'(k * 64));
    idle(2);
    ctrl = 1'b0; step(1'b0, '0);
    for (int k = 1; k <= 3; k++) step(1'b1, 14'(k * 64));
    ctrl = 1'b1; step(1'b0, '0);
    for (int k = 4; k <= 12; k++) step(1'b1, 14'(k * 64));
    ctrl = 1'b0;
    for (int k = 1; k <= 9; k++) step(1'b1, 14'(k * 32));
    idle(4);

    // backpressure until full, then drain
    m_tready = 1'b0;
    for (int k = 1; k <= 20; k++) step(1'b1, 14'(k * 64));
    idle(3);
    m_tready = 1'b1;
    idle(20);
    clr_ovf = 1'b1; step(1'b0, '0); clr_ovf = 1'b0;

    // clear coinciding with a drop
    m_tready = 1'b0;
    for (int k = 1; k <= 17; k++) step(1'b1, 14'($urandom));
    clr_ovf = 1'b1; step(1'b1, 14'($urandom)); clr_ovf = 1'b0;
    step(1'b1, 14'($urandom));
    idle(2);
    m_tready = 1'b1;
    idle(20);
    clr_ovf = 1'b1; step(1'b0, '0); clr_ovf = 1'b0;

    // full with simultaneous read across pointer wrap
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) step(1'b1, 14'($urandom));
    idle(1);
    m_tready = 1'b1;
    for (int k = 0; k < 40; k++) step(1'b1, 14'($urandom));
    idle(20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      m_tready = ($urandom_range(0, 2) != 0);
      clr_ovf  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 59) == 0) ctrl = ~ctrl;
      case ($urandom_range(0, 7))
        0:       dv = 14'h1FFF;
        1:       dv = 14'h2000;
        default: dv = 14'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, dv);
    end
    clr_ovf = 1'b0;
    m_tready = 1'b1;
    idle(24);

    // asynchronous reset with eight entries buffered
    m_tready = 1'b0;
    for (int k = 1; k <= 8; k++) step(1'b1, 14'(k * 100));
    idle(2);
    #3 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    m_tready = 1'b1;
    step(1'b1, 14'h0123);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
